// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: shared fetch/decode constants, fetcher FSM states and immediate helpers
package inst_fetcher_pkg;
  localparam int ADDR_WID = 32;
  localparam int INST_WID = 32;
  localparam int DATA_WID = 32;
  localparam int IF_STATE_WID = 2;
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [6:0] OPCODE_B = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;
  typedef enum logic [IF_STATE_WID-1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;
  function automatic logic [ADDR_WID-1:0] j_imm(input logic [INST_WID-1:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic [ADDR_WID-1:0] b_imm(input logic [INST_WID-1:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/inst_fetcher_branch_predictor.sv
// branch_predictor: table of 2-bit saturating counters, read by buffered PC, trained on ROB commit
module branch_predictor
  import inst_fetcher_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             taken
);
  logic [2**IDX_W-1:0][1:0] cnt_q, cnt_d;
  logic [1:0] cur;
  always_comb begin
    cnt_d = cnt_q;
    cur = cnt_q[upd_idx];
    if (rdy && upd)
      cnt_d[upd_idx] = upd_taken ? (cur == 2'd3 ? cur : cur + 2'd1)
                                 : (cur == 2'd0 ? cur : cur - 2'd1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= {(2**IDX_W){2'b01}};
    else cnt_q <= cnt_d;
  assign taken = cnt_q[rd_idx][1];
endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: PC holder, one-outstanding fetch FSM and next-PC predictor feeding the decoder.
// Define INST_FETCHER_BHT_EN to predict B-type branches with a trained BHT instead of not-taken.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [ADDR_WID-1:0] RESET_PC = 32'h0,
  parameter int BHT_IDX_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rob_nxt_full,
  input  logic                rs_nxt_full,
  input  logic                lsb_nxt_full,
  input  logic                rollback,
  input  logic [ADDR_WID-1:0] rollback_pc,
  output logic                mem_req,
  output logic [ADDR_WID-1:0] mem_addr,
  input  logic                mem_done,
  input  logic [DATA_WID-1:0] mem_data,
  output logic                inst_rdy,
  output logic [INST_WID-1:0] inst,
  output logic [ADDR_WID-1:0] inst_pc,
  output logic                inst_pred_jump,
  input  logic                br_upd,
  input  logic [ADDR_WID-1:0] br_upd_pc,
  input  logic                br_upd_taken
);
  if_state_e state_q, state_d;
  logic [ADDR_WID-1:0] pc_q, pc_d, buf_pc_q, buf_pc_d, mem_addr_q, mem_addr_d, inst_pc_q, inst_pc_d;
  logic [INST_WID-1:0] buf_q, buf_d, inst_q, inst_d;
  logic buf_valid_q, buf_valid_d, drop_q, drop_d, mem_req_q, mem_req_d;
  logic inst_rdy_q, inst_rdy_d, inst_pred_q, inst_pred_d;
  logic pred_taken, is_jal, b_taken, stall;
  logic [ADDR_WID-1:0] next_pc;
`ifdef INST_FETCHER_BHT_EN
  logic unused_pc;
  branch_predictor #(.IDX_W(BHT_IDX_W)) u_bp (
    .clk(clk), .rst(rst), .rdy(rdy), .upd(br_upd),
    .upd_idx(br_upd_pc[BHT_IDX_W+1:2]), .upd_taken(br_upd_taken),
    .rd_idx(buf_pc_q[BHT_IDX_W+1:2]), .taken(pred_taken)
  );
  assign unused_pc = ^{br_upd_pc[1:0], br_upd_pc[ADDR_WID-1:BHT_IDX_W+2]};
`else
  logic unused_br;
  assign pred_taken = 1'b0;
  assign unused_br = ^{br_upd, br_upd_pc, br_upd_taken, 1'(BHT_IDX_W)};
`endif
  assign is_jal = buf_q[6:0] == OPCODE_JAL;
  assign b_taken = (buf_q[6:0] == OPCODE_B) && pred_taken;
  assign next_pc = buf_pc_q + (is_jal ? j_imm(buf_q) : b_taken ? b_imm(buf_q) : 32'd4);
  assign stall = rob_nxt_full || rs_nxt_full || lsb_nxt_full;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    buf_d = buf_q;
    buf_pc_d = buf_pc_q;
    buf_valid_d = buf_valid_q;
    drop_d = drop_q;
    mem_req_d = mem_req_q;
    mem_addr_d = mem_addr_q;
    inst_rdy_d = 1'b0;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    inst_pred_d = inst_pred_q;
    if (rdy && rollback) begin
      pc_d = rollback_pc;
      buf_valid_d = 1'b0;
      // an in-flight request must still complete; its data is thrown away later
      if (state_q == S_WAIT && !mem_done) drop_d = 1'b1;
      else begin
        state_d = S_IDLE;
        mem_req_d = 1'b0;
        drop_d = 1'b0;
      end
    end else if (rdy) begin
      case (state_q)
        S_IDLE: begin
          mem_req_d = 1'b1;
          mem_addr_d = pc_q;
          state_d = S_WAIT;
        end
        S_WAIT: if (mem_done) begin
          mem_req_d = 1'b0;
          drop_d = 1'b0;
          buf_d = mem_data;
          buf_pc_d = pc_q;
          buf_valid_d = !drop_q;
          state_d = drop_q ? S_IDLE : S_HOLD;
        end
        S_HOLD: if (!stall && buf_valid_q) begin
          inst_rdy_d = 1'b1;
          inst_d = buf_q;
          inst_pc_d = buf_pc_q;
          inst_pred_d = is_jal || b_taken;
          pc_d = next_pc;
          buf_valid_d = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      buf_q <= '0;
      buf_pc_q <= '0;
      buf_valid_q <= 1'b0;
      drop_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_addr_q <= '0;
      inst_rdy_q <= 1'b0;
      inst_q <= '0;
      inst_pc_q <= '0;
      inst_pred_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      buf_q <= buf_d;
      buf_pc_q <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      drop_q <= drop_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      inst_rdy_q <= inst_rdy_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      inst_pred_q <= inst_pred_d;
    end
  assign mem_req = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign inst_rdy = inst_rdy_q;
  assign inst = inst_q;
  assign inst_pc = inst_pc_q;
  assign inst_pred_jump = inst_pred_q;
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Producer end of the fetch-to-decode interface. Holds the PC, fetches 32-bit words through the memory controller, and predicts the next PC.
- Presents one instruction at a time to the decoder as inst_rdy/inst/inst_pc/inst_pred_jump.
- On ROB rollback it redirects to the corrected PC and discards any in-flight fetch.

Parameters:
RESET_PC, 32'h0, PC loaded at reset
BHT_IDX_W, 8, index width of branch history table (only with INST_FETCHER_BHT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
rdy  in  1  global enable; when 0, all state frozen and no new pulses
rob_nxt_full  in  1  ROB cannot accept an issue next cycle
rs_nxt_full  in  1  reservation station cannot accept next cycle
lsb_nxt_full  in  1  load/store buffer cannot accept next cycle
rollback  in  1  misprediction flush from ROB
rollback_pc  in  32  redirect target
mem_req  out  1  fetch request, held until mem_done
mem_addr  out  32  word address of fetch, held stable while mem_req=1
mem_done  in  1  one-cycle response strobe
mem_data  in  32  fetched word, valid with mem_done
inst_rdy  out  1  one-cycle issue pulse to decoder
inst  out  32  instruction
inst_pc  out  32  its PC
inst_pred_jump  out  1  predicted taken
br_upd  in  1  ROB commit of a B-type instruction
br_upd_pc  in  32  PC of committed branch
br_upd_taken  in  1  actual outcome

Behaviour:
- Reset (rst=0, async): pc=RESET_PC; state=S_IDLE; buffer invalid; mem_req=0; mem_addr=0; inst_rdy=0; inst=0; inst_pc=0; inst_pred_jump=0; drop=0; BHT entries=2'b01 (weakly not-taken).
- States:
  - S_IDLE: assert mem_req with mem_addr=pc; go to S_WAIT.
  - S_WAIT: on mem_done, latch mem_data into buffer with buf_pc=pc; deassert mem_req; go to S_HOLD.
  - S_HOLD: if none of the three nxt_full signals is set, drive a registered inst_rdy=1 for exactly one cycle with inst/inst_pc/inst_pred_jump from the buffer. In the same cycle set pc=next_pc, invalidate the buffer, go to S_IDLE.
- inst/inst_pc/inst_pred_jump hold their values after the pulse. The decoder samples them only while inst_rdy=1.
- Minimum request-to-issue latency: 1 cycle (IDLE) + memory latency + 1 cycle (HOLD). At most one instruction is outstanding.
- next_pc, computed from the buffered word (opcode in inst[6:0]):
  - JAL: buf_pc + sext J-imm; pred=1.
  - B: buf_pc + sext B-imm if predicted taken, else buf_pc+4; pred=prediction.
  - All others, including JALR: buf_pc+4; pred=0.
  - Adds are 32-bit modular; wrap-around is silently allowed.
- Rollback (has priority over every other event in the same cycle):
  - pc=rollback_pc; buffer invalidated; inst_rdy forced 0 that cycle.
  - If in S_WAIT and mem_done has not arrived in that same cycle: set drop=1, keep mem_req asserted to complete the transaction, stay in S_WAIT. The response is discarded, drop clears, and the FSM goes to S_IDLE.
  - If mem_done coincides with rollback: discard the data and go to S_IDLE.
  - Otherwise go to S_IDLE.
  - A second rollback while drop=1 only updates pc.
- rdy=0: no state change, inst_rdy=0, mem_req/mem_addr hold.
- br_upd is accepted in any state, including during rollback.

Optional Feature:
INST_FETCHER_BHT_EN
- Defined: a BHT of 2^BHT_IDX_W 2-bit saturating counters, indexed by pc[BHT_IDX_W+1:2].
  - B prediction = counter[1].
  - On br_upd, the counter at br_upd_pc's index increments on taken and decrements on not-taken, saturating at 0/3.
  - Update is visible to predictions one cycle later.
- Undefined: static prediction; B is always not-taken, br_upd* are ignored, and no table is synthesised.

Decomposition:
- Shared constants header (already used by decoder/ROB): OPCODE_JAL, OPCODE_B, OPCODE_JALR, ADDR_WID, INST_WID, DATA_WID.
- Add IF_STATE_WID plus localparams S_IDLE/S_WAIT/S_HOLD locally.
- One natural sub-module: branch_predictor (BHT array plus update logic), instantiated only under INST_FETCHER_BHT_EN.

Test Plan:
- Reset release, memory returns 32'h00500093 (addi) at 0 after 3 cycles, no stall -> one inst_rdy pulse with inst=32'h00500093, inst_pc=0, pred=0; next mem_addr=4.
- Word at 0x10 is 32'h0080006F (jal x0,+8) -> pred=1; next mem_addr=0x18.
- rs_nxt_full=1 for 5 cycles in S_HOLD -> inst_rdy stays 0 and buffer is unchanged; pulse occurs in the first cycle after release.
- Rollback with rollback_pc=0x100 while in S_WAIT, mem_done two cycles later -> response dropped, no inst_rdy; next mem_req with addr 0x100.
- Rollback coinciding with inst_rdy condition in S_HOLD -> inst_rdy=0; refetch from rollback_pc.
- BHT_EN: two br_upd taken at pc 0x20, then fetch beq at 0x20 with +16 -> pred=1, next addr 0x30. Without the macro -> pred=0, next addr 0x24.
